// File: rtl/radix_seq_mult.sv
// Sequential unsigned N x N multiplier retiring K multiplier bits per cycle,
// with start/ready/done handshake, synchronous abort and early termination.
module radix_seq_mult #(
  parameter int N = 256,
  parameter int K = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] prod
);

  localparam int DIGITS = N / K;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  generate
    if (N < 2 || K < 1 || K > 8 || (N % K) != 0) begin : g_param_check
      $error("radix_seq_mult: N must be >= 2, K in 1..8 and K must divide N");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [N-1:0]   a_sh;
  logic [N-1:0]   b_r;
  logic [N-1:0]   a_nxt;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] acc_nxt;
  logic [2*N-1:0] pp_ext;
  logic [N+K-1:0] pp;
  logic [K-1:0]   d;
  logic [CW-1:0]  cnt;
  logic [31:0]    sh_amt;
  logic           last_iter;
  logic           accept;

  // One radix-2^K digit step: partial product weighted by its digit position.
  always_comb begin
    d         = a_sh[K-1:0];
    pp        = {{K{1'b0}}, b_r} * {{N{1'b0}}, d};
    pp_ext    = (2*N)'(pp);
    sh_amt    = 32'(K) * 32'(cnt);
    acc_nxt   = acc + (pp_ext << sh_amt);
    a_nxt     = a_sh >> K;
    last_iter = (a_nxt == '0) || (cnt == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Abort takes priority over start in every state; alone it only affects RUN.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start && !abort) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (abort) begin
          state_d = IDLE;
        end else if (last_iter) begin
          state_d = DONE;
        end
      end
      DONE: begin
        ready = 1'b1;
        done  = 1'b1;
        if (start && !abort) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_r  <= '0;
      acc  <= '0;
      cnt  <= '0;
      prod <= '0;
    end else if (accept) begin
      a_sh <= a;
      b_r  <= b;
      acc  <= '0;
      cnt  <= '0;
    end else if (state_q == RUN && !abort) begin
      acc  <= acc_nxt;
      a_sh <= a_nxt;
      cnt  <= cnt + CW'(1);
      if (last_iter) begin
        prod <= acc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_radix_seq_mult.sv
// Self-checking bench for radix_seq_mult: three instances (N=8/K=2, N=8/K=1,
// N=256/K=4) checked every cycle against a transaction-level product model.
module tb_radix_seq_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [2:0]     start;
  logic [2:0]     abort;
  logic [255:0]   a [3];
  logic [255:0]   b [3];

  logic           rdy0, rdy1, rdy2;
  logic           bsy0, bsy1, bsy2;
  logic           dn0, dn1, dn2;
  logic [15:0]    prod0, prod1;
  logic [511:0]   prod2;

  logic [2:0]     rdy, bsy, dn;
  logic [511:0]   prod_o [3];

  always_comb begin
    rdy       = {rdy2, rdy1, rdy0};
    bsy       = {bsy2, bsy1, bsy0};
    dn        = {dn2, dn1, dn0};
    prod_o[0] = {496'b0, prod0};
    prod_o[1] = {496'b0, prod1};
    prod_o[2] = prod2;
  end

  radix_seq_mult #(.N(8), .K(2)) u_n8k2 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
    .a(a[0][7:0]), .b(b[0][7:0]),
    .ready(rdy0), .busy(bsy0), .done(dn0), .prod(prod0)
  );

  radix_seq_mult #(.N(8), .K(1)) u_n8k1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
    .a(a[1][7:0]), .b(b[1][7:0]),
    .ready(rdy1), .busy(bsy1), .done(dn1), .prod(prod1)
  );

  radix_seq_mult #(.N(256), .K(4)) u_n256k4 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]),
    .a(a[2]), .b(b[2]),
    .ready(rdy2), .busy(bsy2), .done(dn2), .prod(prod2)
  );

  int checks;
  int errors;

  function automatic int k_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
  endfunction

  function automatic logic [255:0] opmask(input int i);
    logic [255:0] m;
    m = (i == 2) ? '1 : 256'hFF;
    return m;
  endfunction

  // Iterations needed: significant multiplier bits, K at a time, at least one.
  function automatic int iters(input logic [255:0] x, input int k);
    int top;
    top = 0;
    for (int j = 0; j < 256; j++) if (x[j]) top = j + 1;
    return (top == 0) ? 1 : (top + k - 1) / k;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[j*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string nm, input int i, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h required %0h", nm, i, got, exp);
    end
  endtask

  // Model: remaining run cycles, pending product, and the visible result.
  int           rem   [3];
  logic         mdone [3];
  logic [511:0] mprod [3];
  logic [511:0] pend  [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        rem[i]   <= 0;
        mdone[i] <= 1'b0;
        mprod[i] <= '0;
        pend[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        mdone[i] <= 1'b0;
        if (rem[i] > 0) begin
          if (abort[i]) begin
            rem[i] <= 0;
          end else begin
            rem[i] <= rem[i] - 1;
            if (rem[i] == 1) begin
              mdone[i] <= 1'b1;
              mprod[i] <= pend[i];
            end
          end
        end else if (start[i] && !abort[i]) begin
          rem[i]  <= iters(a[i] & opmask(i), k_of(i));
          pend[i] <= {256'b0, a[i] & opmask(i)} * {256'b0, b[i] & opmask(i)};
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        chk("ready", i, rdy[i], rem[i] == 0);
        chk("busy",  i, bsy[i], rem[i] > 0);
        chk("done",  i, dn[i],  mdone[i]);
        chk("prod",  i, prod_o[i], mprod[i]);
      end
    end
  end

  task automatic launch(input int i, input logic [255:0] av, input logic [255:0] bv);
    @(negedge clk);
    a[i]     = av;
    b[i]     = bv;
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget, output int cyc);
    cyc = 0;
    while (!dn[i] && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (!dn[i]) begin
      checks++;
      errors++;
      $display("FAIL done_timeout[%0d]: done=0 after %0d cycles, required done=1", i, budget);
    end
  endtask

  int           cyc;
  int           gap;
  int           em;
  logic [255:0] ra;
  logic [255:0] rb;
  logic [511:0] ones_sq;

  initial begin
    checks  = 0;
    errors  = 0;
    start   = '0;
    abort   = '0;
    for (int i = 0; i < 3; i++) begin
      a[i] = '0;
      b[i] = '0;
    end
    ones_sq = {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1};
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", i, rdy[i], 1);
      chk("rst_busy",  i, bsy[i], 0);
      chk("rst_done",  i, dn[i],  0);
      chk("rst_prod",  i, prod_o[i], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Full-length K=2 product
    launch(0, 'hFF, 'hFF);
    wait_done(0, 20, cyc);
    chk("t1_cycles", 0, cyc, 4);
    chk("t1_prod",   0, prod_o[0], 'hFE01);
    chk("t1_model",  0, mprod[0],  'hFE01);
    @(negedge clk);
    chk("t1_ready_after", 0, rdy[0], 1);
    chk("t1_done_after",  0, dn[0],  0);

    // Early termination, including a zero multiplier
    launch(0, 'h03, 'h05);
    wait_done(0, 20, cyc);
    chk("t2_cycles", 0, cyc, 1);
    chk("t2_prod",   0, prod_o[0], 'h000F);
    launch(0, 'h00, 'hAB);
    wait_done(0, 20, cyc);
    chk("t2z_cycles", 0, cyc, 1);
    chk("t2z_prod",   0, prod_o[0], 0);

    // Operands change after acceptance
    launch(0, 'h80, 'h02);
    @(negedge clk);
    a[0] = 'h7F;
    b[0] = 'hFF;
    wait_done(0, 20, cyc);
    chk("t3_cycles", 0, cyc, 3);
    chk("t3_prod",   0, prod_o[0], 'h0100);

    // K=1 abort with simultaneous start; previous product must survive
    launch(1, 'h05, 'h03);
    wait_done(1, 20, cyc);
    chk("t4_pre_cycles", 1, cyc, 3);
    chk("t4_pre_prod",   1, prod_o[1], 'h0F);
    launch(1, 'hFF, 'h01);
    @(negedge clk);
    @(negedge clk);
    abort[1] = 1'b1;
    start[1] = 1'b1;
    a[1]     = 'h11;
    @(negedge clk);
    abort[1] = 1'b0;
    start[1] = 1'b0;
    chk("t4_busy",  1, bsy[1], 0);
    chk("t4_ready", 1, rdy[1], 1);
    chk("t4_prod",  1, prod_o[1], 'h0F);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("t4_no_done", 1, dn[1], 0);
    end

    // Back-to-back with start held high; one done per m+1 cycles
    @(negedge clk);
    a[0]     = 256'($urandom_range(0, 255));
    b[0]     = 256'($urandom_range(0, 255));
    start[0] = 1'b1;
    wait_done(0, 20, cyc);
    for (int j = 0; j < 8; j++) begin
      ra   = 256'($urandom_range(0, 255));
      a[0] = ra;
      b[0] = 256'($urandom_range(0, 255));
      em   = iters(ra, 2);
      gap  = 0;
      do begin
        @(negedge clk);
        gap++;
        if (!dn[0]) begin
          a[0] = 256'($urandom_range(0, 255));
          b[0] = 256'($urandom_range(0, 255));
        end
      end while (!dn[0] && gap < 40);
      chk("t5_period", 0, gap, em + 1);
    end
    start[0] = 1'b0;
    repeat (2) @(negedge clk);

    // N=256, K=4 random operands, back-to-back, noise on inputs while busy
    for (int n = 0; n <= 1000; n++) begin
      if (n == 1000) begin
        ra = '1;
        rb = '1;
      end else begin
        ra = rnd256() >> $urandom_range(0, 255);
        rb = rnd256();
      end
      a[2]     = ra;
      b[2]     = rb;
      start[2] = 1'b1;
      @(negedge clk);
      cyc = 0;
      while (!dn[2] && cyc < 80) begin
        a[2]     = rnd256();
        b[2]     = rnd256();
        start[2] = ($urandom_range(0, 3) == 0);
        @(negedge clk);
        cyc++;
      end
      if (!dn[2]) begin
        checks++;
        errors++;
        $display("FAIL t6_timeout[2]: done=0 after %0d cycles, required done=1", cyc);
      end
    end
    chk("t6_ones_prod",  2, prod_o[2], ones_sq);
    chk("t6_ones_model", 2, mprod[2],  ones_sq);
    start[2] = 1'b0;
    @(negedge clk);

    // Asynchronous reset mid-run, then a fresh operation
    launch(2, rnd256() | (256'b1 << 255), rnd256());
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("t7_ready", i, rdy[i], 1);
      chk("t7_busy",  i, bsy[i], 0);
      chk("t7_done",  i, dn[i],  0);
      chk("t7_prod",  i, prod_o[i], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    launch(2, 256'h1_0000, 256'h3);
    wait_done(2, 80, cyc);
    chk("t7_cycles", 2, cyc, 5);
    chk("t7_prod",   2, prod_o[2], 'h3_0000);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
